// File: rtl/truth_table_sequencer.sv
// Truth-table sweeper: steps a gate under test through every input vector,
// records its output per vector and scores each entry against a golden function.
module truth_table_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           mode,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 gate_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 mismatch,
    output logic [N_IN:0]        err_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] IDX_MAX = '1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic [2:0]      mode_q;
    logic            cnt_last;
    logic            idx_last;
    logic            golden_bit;

    // Majority is strictly more than half of the inputs (integer halving).
    function automatic logic golden(input logic [2:0] m, input logic [N_IN-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < N_IN; i++) begin
            ones += int'(v[i]);
        end
        case (m)
            3'd0:    golden = &v;
            3'd1:    golden = |v;
            3'd2:    golden = ^v;
            3'd3:    golden = ~&v;
            3'd4:    golden = ~|v;
            3'd5:    golden = ~^v;
            3'd6:    golden = (ones > N_IN / 2);
            default: golden = 1'b0;
        endcase
    endfunction

    assign cnt_last   = (cnt == CNT_MAX);
    assign idx_last   = (idx == IDX_MAX);
    assign golden_bit = golden(mode_q, idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt_last) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy      = 1'b1;
                state_nxt = idx_last ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results survive DONE and IDLE; only an accepted start or reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            mode_q    <= '0;
            vec_out   <= '0;
            table_out <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        idx       <= '0;
                        cnt       <= '0;
                        vec_out   <= '0;
                        table_out <= '0;
                        mismatch  <= 1'b0;
                        err_count <= '0;
                    end
                end
                S_SETTLE: begin
                    if (!cnt_last) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    table_out[idx] <= gate_in;
                    if (gate_in != golden_bit) begin
                        mismatch  <= 1'b1;
                        err_count <= err_count + 1'b1;
                    end
                    cnt <= '0;
                    if (!idx_last) begin
                        idx     <= idx + 1'b1;
                        vec_out <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: three instances (2-in/settle 1, 3-in/settle 1,
// 2-in/settle 3) checked every cycle against a cycle-arithmetic model.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start = 3'b000;
    logic [2:0] mode0 = 3'd0, mode1 = 3'd0, mode2 = 3'd0;

    logic [1:0] vec0;  logic gate0, busy0, done0, mis0; logic [3:0] tab0; logic [2:0] err0;
    logic [2:0] vec1;  logic gate1, busy1, done1, mis1; logic [7:0] tab1; logic [3:0] err1;
    logic [1:0] vec2;  logic gate2, busy2, done2, mis2; logic [3:0] tab2; logic [2:0] err2;

    assign gate0 = &vec0;
    assign gate1 = ^vec1;
    assign gate2 = &vec2;

    truth_table_sequencer #(.N_IN(2), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode0), .vec_out(vec0),
        .gate_in(gate0), .busy(busy0), .done(done0), .table_out(tab0),
        .mismatch(mis0), .err_count(err0));
    truth_table_sequencer #(.N_IN(3), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode1), .vec_out(vec1),
        .gate_in(gate1), .busy(busy1), .done(done1), .table_out(tab1),
        .mismatch(mis1), .err_count(err1));
    truth_table_sequencer #(.N_IN(2), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode2), .vec_out(vec2),
        .gate_in(gate2), .busy(busy2), .done(done2), .table_out(tab2),
        .mismatch(mis2), .err_count(err2));

    always #5 clk = ~clk;

    int pn[3] = '{2, 3, 2};
    int ps[3] = '{1, 1, 3};
    int pg[3] = '{0, 1, 0};   // attached gate: 0 AND, 1 XOR

    bit started[3];
    int e0[3];
    int mmode[3];
    int done_c[3] = '{-1, -1, -1};
    int edge_n = 0;
    bit chk_en = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    function automatic int popcount(input int k);
        int p;
        p = 0;
        for (int b = 0; b < 8; b++) p += (k >> b) & 1;
        return p;
    endfunction

    function automatic bit gate_fn(input int g, input int n, input int k);
        if (g == 0) return (k == (1 << n) - 1);
        return (popcount(k) % 2) == 1;
    endfunction

    function automatic bit golden_fn(input int m, input int n, input int k);
        int pc;
        pc = popcount(k);
        case (m)
            0: return pc == n;
            1: return pc > 0;
            2: return (pc % 2) == 1;
            3: return pc != n;
            4: return pc == 0;
            5: return (pc % 2) == 0;
            6: return pc > n / 2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int count_err(input int m, input int n, input int g);
        int e;
        e = 0;
        for (int k = 0; k < (1 << n); k++)
            if (gate_fn(g, n, k) != golden_fn(m, n, k)) e++;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a start is accepted only when idle (not in a sweep nor the DONE cycle).
    always @(posedge clk) begin
        int md[3];
        int cc;
        edge_n++;
        md[0] = int'(mode0); md[1] = int'(mode1); md[2] = int'(mode2);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                started[i] = 1'b0;
            end else begin
                cc = edge_n - e0[i];
                if (start[i] && (!started[i] || cc >= (1 << pn[i]) * (ps[i] + 1) + 2)) begin
                    started[i] = 1'b1;
                    e0[i]      = edge_n;
                    mmode[i]   = md[i];
                    done_c[i]  = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic ab, ad, am;
        logic [63:0] av, at, ae;
        logic eb, ed, em;
        logic [63:0] ev, et, ee;
        int c, total, ns, nv;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                case (i)
                    0: begin ab = busy0; ad = done0; av = 64'(vec0); at = 64'(tab0); am = mis0; ae = 64'(err0); end
                    1: begin ab = busy1; ad = done1; av = 64'(vec1); at = 64'(tab1); am = mis1; ae = 64'(err1); end
                    default: begin ab = busy2; ad = done2; av = 64'(vec2); at = 64'(tab2); am = mis2; ae = 64'(err2); end
                endcase
                c = edge_n - e0[i] + 1;
                eb = 0; ed = 0; em = 0; ev = '0; et = '0; ee = '0;
                if (started[i]) begin
                    nv    = 1 << pn[i];
                    total = nv * (ps[i] + 1);
                    eb = (c <= total);
                    ed = (c == total + 1);
                    ev = 64'((c - 1) / (ps[i] + 1));
                    ns = (c - 1) / (ps[i] + 1);
                    if (ns > nv) ns = nv;
                    for (int k = 0; k < ns; k++) begin
                        et[k] = gate_fn(pg[i], pn[i], k);
                        if (gate_fn(pg[i], pn[i], k) != golden_fn(mmode[i], pn[i], k)) ee++;
                    end
                    em = (ee != 0);
                end
                if (ad) done_c[i] = c;
                chk($sformatf("dut%0d busy", i), 64'(ab), 64'(eb));
                chk($sformatf("dut%0d done", i), 64'(ad), 64'(ed));
                chk($sformatf("dut%0d table_out", i), at, et);
                chk($sformatf("dut%0d mismatch", i), 64'(am), 64'(em));
                chk($sformatf("dut%0d err_count", i), ae, ee);
                if (!started[i] || eb) chk($sformatf("dut%0d vec_out", i), av, ev);
            end
        end
    end

    task automatic pulse(input int i, input logic [2:0] m);
        @(posedge clk); #1;
        start[i] = 1'b1;
        case (i)
            0: mode0 = m;
            1: mode1 = m;
            default: mode2 = m;
        endcase
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    initial begin
        chk("model OR vs AND gate errors", 64'(count_err(1, 2, 0)), 64'd2);
        chk("model MAJ vs AND gate errors", 64'(count_err(6, 2, 0)), 64'd0);
        chk("model XOR vs XOR3 gate errors", 64'(count_err(2, 3, 1)), 64'd0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        pulse(0, 3'd0);
        repeat (11) @(posedge clk); #1;
        chk("and table", 64'(tab0), 64'h8);
        chk("and mismatch", 64'(mis0), 64'd0);
        chk("and err", 64'(err0), 64'd0);
        chk("and done cycle", 64'(done_c[0]), 64'd9);

        pulse(0, 3'd1);
        repeat (11) @(posedge clk); #1;
        chk("or table", 64'(tab0), 64'h8);
        chk("or mismatch", 64'(mis0), 64'd1);
        chk("or err", 64'(err0), 64'd2);

        pulse(1, 3'd2);
        repeat (19) @(posedge clk); #1;
        chk("xor3 table", 64'(tab1), 64'h96);
        chk("xor3 err", 64'(err1), 64'd0);
        chk("xor3 done cycle", 64'(done_c[1]), 64'd17);

        pulse(2, 3'd6);
        repeat (19) @(posedge clk); #1;
        chk("maj table", 64'(tab2), 64'h8);
        chk("maj mismatch", 64'(mis2), 64'd0);
        chk("maj done cycle", 64'(done_c[2]), 64'd17);

        // restart attempt at cycle 3 with a different mode
        pulse(0, 3'd0);
        repeat (2) @(posedge clk); #1;
        start[0] = 1'b1; mode0 = 3'd1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (8) @(posedge clk); #1;
        chk("busy-start err", 64'(err0), 64'd0);
        chk("busy-start mismatch", 64'(mis0), 64'd0);
        chk("busy-start done cycle", 64'(done_c[0]), 64'd9);

        // reset during cycle 4 of a sweep
        pulse(0, 3'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset vec", 64'(vec0), 64'd0);
        chk("reset table", 64'(tab0), 64'd0);
        repeat (12) @(posedge clk); #1;
        chk("reset no done", 64'(done_c[0]), 64'(-1));

        pulse(0, 3'd0);
        repeat (11) @(posedge clk); #1;
        chk("post-reset table", 64'(tab0), 64'h8);
        chk("post-reset done cycle", 64'(done_c[0]), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Parametrised hardware truth-table sweeper for combinational gate blocks. It drives every input combination of an N_IN-input gate under test and waits a programmable settle time per vector. It samples the gate output, builds the measured truth table, and checks each entry against an internal golden model selected by a mode code. It sits beside any gate instance in the logic-gates library as a synthesizable, self-checking replacement for hand-stepped vector sequences.

## Interface
- N_IN, default 2, number of gate inputs (1..6); the sweep covers 2^N_IN vectors.
- SETTLE, default 1, cycles a vector is held before sampling (>= 1).
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- start  input  1  starts a sweep when sampled high in IDLE.
- mode  input  3  golden function:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 MAJ: 1 when more than N_IN/2 inputs are 1.
  - 7 reserved: golden constant 0.
- vec_out  output  N_IN  vector driven to the gate; bit N_IN-1 is the leftmost (first-listed) input.
- gate_in  input  1  gate output returned from the gate under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at sweep end.
- table_out  output  2^N_IN  measured truth table; bit k is the output for vector k.
- mismatch  output  1  sticky: high if any sampled entry differed from golden.
- err_count  output  N_IN+1  number of mismatching entries in the last sweep.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Registers: idx (N_IN bits), settle counter, latched mode.
- IDLE: busy=0.
  - On start=1: latch mode, set idx=0, vec_out=0, clear table_out, mismatch and err_count, then go to SETTLE.
- SETTLE: busy=1, vec_out=idx.
  - The counter runs from 0 to SETTLE-1; at SETTLE-1 go to SAMPLE.
- SAMPLE: lasts one cycle; vec_out remains idx.
  - table_out[idx] <= gate_in.
  - If gate_in != golden(idx): mismatch <= 1 and err_count++.
  - If idx == 2^N_IN-1: go to DONE. Otherwise idx++, vec_out <= idx+1, and return to SETTLE with the counter cleared.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
  - table_out, mismatch and err_count hold until the next accepted start.
- Golden model:
  - Computed combinationally from idx and the latched mode.
  - A mode change during a sweep has no effect.
  - MAJ uses popcount(idx) > N_IN/2 with integer division; for N_IN=2 it is true only for idx=3.
- start while busy or in DONE: ignored, no restart.
- err_count cannot wrap: its maximum is 2^N_IN, which fits in N_IN+1 bits.

## Timing
- Reset values, applied at a clock edge with rst_n=0 from any state: state=IDLE, vec_out=0, busy=0, done=0, table_out=0, mismatch=0, err_count=0, idx=0.
- Reset mid-sweep aborts the sweep with no done pulse. The partial table is discarded.
- Vector k is driven from cycle k*(SETTLE+1)+1 and sampled at cycle (k+1)*(SETTLE+1). Cycle 0 is the edge that samples start.
- done is high exactly in cycle 2^N_IN*(SETTLE+1)+1.
- A new start is accepted no earlier than the cycle after done.
- Sample point: gate_in is registered at the end of the SAMPLE cycle. The gate therefore has SETTLE+1 cycles of stable input before sampling.
- Outputs are registered; there is no combinational path from gate_in to any output.

## Test plan
- AND scenario:
  - Stimulus: N_IN=2, SETTLE=1, 2-input AND gate attached, mode=0, start pulse.
  - Response: vec_out steps 00,01,10,11 each held for 2 cycles; table_out=4'b1000; mismatch=0; err_count=0; done at cycle 9.
- OR golden against AND gate:
  - Stimulus: same gate as above, mode=1.
  - Response: table_out=4'b1000; mismatch=1; err_count=2 (idx 1 and 2).
- 3-input XOR:
  - Stimulus: N_IN=3, SETTLE=1, 3-input XOR gate, mode=2.
  - Response: table_out=8'b10010110; err_count=0; done at cycle 17.
- Slow settle with MAJ:
  - Stimulus: SETTLE=3, N_IN=2, AND gate, mode=6.
  - Response: each vector held for 4 cycles; done at cycle 17; table_out=4'b1000; mismatch=0 (MAJ equals AND at N_IN=2).
- Reset mid-sweep:
  - Stimulus: rst_n=0 for one edge at cycle 4 of a sweep.
  - Response: next cycle busy=0, vec_out=0, table_out=0, no done pulse. A fresh start then completes normally.
- Start while busy:
  - Stimulus: start re-asserted at cycle 3, with mode changed to 1 at the same time.
  - Response: no restart; the sweep completes with the original mode and done still at cycle 9.
